display_scan_ctrl: RTL and testbench

Time-multiplexing controller for the 4-digit seven-segment display. It sits directly upstream of the nibble group selector and drives that selector's dig_sel input. It also drives its value input with a frame-synchronised copy of the displayed word. It generates active-low digit anodes, with a dead-time blank at each digit change to prevent ghosting.

---
 rtl/display_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_display_scan_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//
// Time-multiplexing scan controller for a 4-digit seven-segment display.
// It steps a digit slot counter (dig_sel) every CLK_DIV clocks and drives
// active-low anodes. The first BLANK_CYCLES clocks of every slot are dark to
// stop ghosting. It also hands the downstream nibble selector a frame-
// synchronised copy of the displayed word, so a digit never tears mid-frame.
//
// Parameters:
//   CLK_DIV       clock cycles per digit slot (>= 2)
//   BLANK_CYCLES  dark cycles at the start of each slot (< CLK_DIV, 0 = none)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   en          in   scan enable; 0 freezes the scan and darkens the display
//   value_in    in   [15:0] new display word, digit 0 = [3:0]
//   load        in   one-cycle request to display value_in
//   value       out  [15:0] frame-synchronised display word
//   dig_sel     out  [1:0] current digit slot 0..3
//   anode       out  [3:0] active-low digit enables, bit n = digit n
//   frame_tick  out  one-cycle pulse when dig_sel wraps 3 -> 0
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, digits n > 0 whose nibbles n..3 of
//                          the registered value are all zero stay dark.
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] value_in,
  input  logic        load,
  output logic [15:0] value,
  output logic [1:0]  dig_sel,
  output logic [3:0]  anode,
  output logic        frame_tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic [3:0]    anode_q, anode_d;
  logic [15:0]   value_q, value_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic          tick_q;
  logic          slot_end;
  logic          wrap;
  logic [3:0]    digit_en;

  // Per-digit permission to light. Digit 0 is always allowed.
`ifdef LEADING_ZERO_BLANK_EN
  genvar gi;
  assign digit_en[0] = 1'b1;
  generate
    for (gi = 1; gi < 4; gi++) begin : g_lead_zero
      // Lit only if some nibble at or above this digit is non-zero.
      assign digit_en[gi] = |value_q[15:4*gi];
    end
  endgenerate
`else
  assign digit_en = 4'b1111;
`endif

  always_comb begin
    slot_end  = en && (cnt_q == CNT_MAX);
    wrap      = slot_end && (dig_q == 2'd3);
    cnt_d     = cnt_q;
    dig_d     = dig_q;
    value_d   = value_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;

    if (en) begin
      if (slot_end) begin
        cnt_d = '0;
        dig_d = dig_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Double buffer: a load on the wrap cycle goes straight to value;
    // otherwise it waits in shadow until the next wrap.
    if (load) begin
      shadow_d = value_in;
      if (wrap) begin
        value_d   = value_in;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end else if (wrap && pending_q) begin
      value_d   = shadow_q;
      pending_d = 1'b0;
    end

    // Anodes come from the next-state slot/count so they line up with
    // dig_sel on the same cycle.
    if (!en || (cnt_d < BLANK_END)) begin
      anode_d = 4'b1111;
    end else begin
      anode_d = ~((4'b0001 << dig_d) & digit_en);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      dig_q     <= 2'd0;
      anode_q   <= 4'b1111;
      value_q   <= 16'h0000;
      shadow_q  <= 16'h0000;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      anode_q   <= anode_d;
      value_q   <= value_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      tick_q    <= wrap;
    end
  end

  assign value      = value_q;
  assign dig_sel    = dig_q;
  assign anode      = anode_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
//
// Directed bench for display_scan_ctrl with CLK_DIV=4, BLANK_CYCLES=1.
// A position-based reference model (frame position 0..4*CLK_DIV-1) predicts
// each cycle's outputs; predictions go into a scoreboard queue when the
// stimulus is driven and are popped and compared after the clock edge.
// Extra constant checks pin down the key points of each scenario.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

  localparam int CLK_DIV = 4;
  localparam int BLANK   = 1;
  localparam int FRAME   = 4 * CLK_DIV;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] value_in;
  logic        load;
  logic [15:0] value;
  logic [1:0]  dig_sel;
  logic [3:0]  anode;
  logic        frame_tick;

  display_scan_ctrl #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .value_in   (value_in),
    .load       (load),
    .value      (value),
    .dig_sel    (dig_sel),
    .anode      (anode),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  dig;
    logic [3:0]  an;
    logic [15:0] val;
    logic        tick;
  } exp_t;

  exp_t sb_q[$];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;
  int cyc       = 0;

  // Reference model state
  int          m_pos;
  logic [15:0] m_val;
  logic [15:0] m_shadow;
  logic        m_pend;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_pos    = 0;
    m_val    = 16'h0000;
    m_shadow = 16'h0000;
    m_pend   = 1'b0;
  endtask

  task automatic model_advance(input logic e, input logic ld, input logic [15:0] vin,
                               output exp_t ex);
    int   npos;
    int   slot;
    int   c;
    logic wr;
    logic [3:0] an;
    wr   = e && (m_pos == FRAME - 1);
    npos = e ? (wr ? 0 : m_pos + 1) : m_pos;
    slot = npos / CLK_DIV;
    c    = npos % CLK_DIV;
    an   = 4'b1111;
    if (e && c >= BLANK) begin
      an[slot] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (slot > 0 && (m_val >> (4 * slot)) == 16'h0000) an = 4'b1111;
`endif
    end
    if (ld) begin
      m_shadow = vin;
      if (wr) begin
        m_val  = vin;
        m_pend = 1'b0;
      end else begin
        m_pend = 1'b1;
      end
    end else if (wr && m_pend) begin
      m_val  = m_shadow;
      m_pend = 1'b0;
    end
    m_pos   = npos;
    ex.dig  = 2'(slot);
    ex.an   = an;
    ex.val  = m_val;
    ex.tick = wr;
  endtask

  // One clock transaction: drive, predict, clock, compare.
  task automatic step(input logic e, input logic ld, input logic [15:0] vin);
    exp_t ex;
    exp_t got;
    en       = e;
    load     = ld;
    value_in = vin;
    model_advance(e, ld, vin, ex);
    sb_q.push_back(ex);
    @(posedge clk);
    #1;
    cyc++;
    got = sb_q.pop_front();
    $display("cyc %0d en=%0b ld=%0b vin=%h | dig=%0d an=%b val=%h tick=%0b",
             cyc, e, ld, vin, dig_sel, anode, value, frame_tick);
    chk("dig_sel",    {14'd0, dig_sel},    {14'd0, got.dig});
    chk("anode",      {12'd0, anode},      {12'd0, got.an});
    chk("value",      value,               got.val);
    chk("frame_tick", {15'd0, frame_tick}, {15'd0, got.tick});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0000);
  endtask

  // Advance with en=1 until the model sits at frame position p.
  task automatic run_to(input int p);
    int guard;
    guard = 0;
    while (m_pos != p && guard < FRAME + 1) begin
      step(1'b1, 1'b0, 16'h0000);
      guard++;
    end
    chk("run_to_bound", 16'(m_pos), 16'(p));
  endtask

  initial begin
    rst      = 1'b0;
    en       = 1'b0;
    load     = 1'b0;
    value_in = 16'h0000;
    model_reset();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dig",   {14'd0, dig_sel},    16'h0000);
    chk("rst_anode", {12'd0, anode},      16'h000F);
    chk("rst_value", value,               16'h0000);
    chk("rst_tick",  {15'd0, frame_tick}, 16'h0000);
    rst = 1'b0;

    // Scan sequence
    idle(4);
    chk("t1_slot1_dig",   {14'd0, dig_sel}, 16'h0001);
    chk("t1_slot1_blank", {12'd0, anode},   16'h000F);
    idle(1);
    chk("t1_slot1_lit",   {12'd0, anode},   16'h000D);

    // Frame-synchronised load
    step(1'b1, 1'b1, 16'hBEEF);
    run_to(FRAME - 1);
    chk("t2_hold_value", value, 16'h0000);
    idle(1);
    chk("t2_wrap_value", value, 16'hBEEF);
    chk("t2_wrap_tick",  {15'd0, frame_tick}, 16'h0001);
    idle(1);
    chk("t2_tick_drop",  {15'd0, frame_tick}, 16'h0000);

    // Load coincident with wrap, then last-load-wins
    run_to(FRAME - 1);
    step(1'b1, 1'b1, 16'h1234);
    chk("t3_coincident", value, 16'h1234);
    idle(2);
    step(1'b1, 1'b1, 16'h5555);
    idle(1);
    step(1'b1, 1'b1, 16'hABCD);
    step(1'b1, 1'b1, 16'hABCD);
    run_to(FRAME - 1);
    chk("t3_still_1234", value, 16'h1234);
    idle(1);
    chk("t3_last_wins",  value, 16'hABCD);

    // Enable gating at cnt=2, dig_sel=2
    run_to(2 * CLK_DIV + 2);
    for (int i = 0; i < 10; i++) step(1'b0, (i == 4), 16'h0F0F);
    chk("t4_frozen_dig",   {14'd0, dig_sel}, 16'h0002);
    chk("t4_dark",         {12'd0, anode},   16'h000F);
    chk("t4_no_update",    value,            16'hABCD);
    step(1'b1, 1'b0, 16'h0000);
    chk("t4_resume_anode", {12'd0, anode},   16'h000B);
    run_to(FRAME - 1);
    idle(1);
    chk("t4_shadow_apply", value, 16'h0F0F);

    // Asynchronous reset mid-frame with a pending load
    idle(3);
    step(1'b1, 1'b1, 16'h7777);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_anode", {12'd0, anode},      16'h000F);
    chk("t5_async_dig",   {14'd0, dig_sel},    16'h0000);
    chk("t5_async_value", value,               16'h0000);
    chk("t5_async_tick",  {15'd0, frame_tick}, 16'h0000);
    model_reset();
    #1 rst = 1'b0;
    idle(2 * FRAME + 1);
    chk("t5_pending_lost", value, 16'h0000);

    // Leading-zero scenario (all digits lit unless the option is built in)
    step(1'b1, 1'b1, 16'h0050);
    run_to(FRAME - 1);
    idle(1);
    chk("t6_value", value, 16'h0050);
    run_to(CLK_DIV + 1);
    chk("t6_slot1", {12'd0, anode}, 16'h000D);
    run_to(2 * CLK_DIV + 1);
`ifdef LEADING_ZERO_BLANK_EN
    chk("t6_slot2", {12'd0, anode}, 16'h000F);
`else
    chk("t6_slot2", {12'd0, anode}, 16'h000B);
`endif
    run_to(3 * CLK_DIV + 2);
`ifdef LEADING_ZERO_BLANK_EN
    chk("t6_slot3", {12'd0, anode}, 16'h000F);
`else
    chk("t6_slot3", {12'd0, anode}, 16'h0007);
`endif
    run_to(1);
    chk("t6_slot0", {12'd0, anode}, 16'h000E);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
